// File: rtl/dqn_pkg.sv
// Shared definitions for the weight bank: default geometry, the bank
// state encoding and the load-count width.
package dqn_pkg;

    localparam int DATA_W_DEF    = 16;
    localparam int N_WORDS_DEF   = 9;
    localparam int BASE_ADDR_DEF = 10;
    localparam int CNT_W         = $clog2(N_WORDS_DEF + 1);

    // EMPTY: no word loaded, LOADING: some loaded, FULL: all loaded,
    // COMMIT: one-cycle publish of the shadow set into the active set.
    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_LOADING = 2'd1,
        ST_FULL    = 2'd2,
        ST_COMMIT  = 2'd3
    } bank_state_e;

endpackage : dqn_pkg

// File: rtl/weight_bank_popcount.sv
// Combinational population count of a WIDTH-bit vector.
module popcount #(
    parameter int WIDTH = 9
) (
    input  logic [WIDTH-1:0]             bits,
    output logic [$clog2(WIDTH+1)-1:0]   count
);

    localparam int CW = $clog2(WIDTH + 1);

    // Sum the set bits.
    always_comb begin
        // NOTE: every variable written in always_comb gets a value before any
        // conditional path, otherwise the tool infers a latch to hold it.
        count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count = count + CW'(bits[i]);
        end
    end

endmodule : popcount

// File: rtl/weight_bank.sv
// Weight bank: N_WORDS x DATA_W weight registers loaded word by word from a
// controller address space starting at BASE_ADDR.
// Build option WEIGHT_BANK_SHADOW_EN: when defined, writes land in a shadow
// set and a commit in FULL publishes it to the active set two edges later;
// when undefined, writes update the active set directly and commit is ignored.
module weight_bank
    import dqn_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int N_WORDS   = N_WORDS_DEF,
    parameter int ADDR_W    = 4,
    parameter int BASE_ADDR = BASE_ADDR_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         commit,
    input  logic                         clear,
    output logic [N_WORDS*DATA_W-1:0]    w_flat,
    output logic [$clog2(N_WORDS+1)-1:0] load_cnt,
    output logic                         full,
    output logic                         err_oob
);

    localparam int LCNT_W = $clog2(N_WORDS + 1);

    bank_state_e             state_q, state_d;
    logic [N_WORDS-1:0]      loaded_q, loaded_d;
    logic                    err_oob_q, err_oob_d;
    logic [DATA_W-1:0]       active_q [N_WORDS];
    logic [DATA_W-1:0]       active_d [N_WORDS];
`ifdef WEIGHT_BANK_SHADOW_EN
    logic [DATA_W-1:0]       shadow_q [N_WORDS];
    logic [DATA_W-1:0]       shadow_d [N_WORDS];
`else
    logic                    unused_commit;
    assign unused_commit = commit;
`endif

    logic        wr_acc;
    logic        in_range;
    logic [31:0] addr_ext;
    logic [31:0] idx_ext;

    // Address decode: widen before comparing so BASE_ADDR+N_WORDS never wraps.
    always_comb begin
        addr_ext = 32'(wr_addr);
        idx_ext  = addr_ext - 32'(BASE_ADDR);
        in_range = (addr_ext >= 32'(BASE_ADDR)) &&
                   (addr_ext <  32'(BASE_ADDR + N_WORDS));
        wr_acc   = wr_valid && wr_ready;
    end

    // Output decode: writes are refused in reset and during the publish cycle.
    always_comb begin
`ifdef WEIGHT_BANK_SHADOW_EN
        wr_ready = rst && (state_q != ST_COMMIT);
`else
        wr_ready = rst;
`endif
    end

    // Storage update with priority clear > commit > write.
    always_comb begin
        loaded_d  = loaded_q;
        err_oob_d = err_oob_q;
        active_d  = active_q;
`ifdef WEIGHT_BANK_SHADOW_EN
        shadow_d  = shadow_q;
`endif
        if (clear) begin
            // A write accepted alongside clear is dropped on purpose.
            loaded_d  = '0;
            err_oob_d = 1'b0;
        end else begin
`ifdef WEIGHT_BANK_SHADOW_EN
            if (state_q == ST_COMMIT) begin
                active_d = shadow_q;
                loaded_d = '0;
            end
`endif
            if (wr_acc) begin
                if (in_range) begin
                    for (int i = 0; i < N_WORDS; i++) begin
                        if (idx_ext == 32'(i)) begin
`ifdef WEIGHT_BANK_SHADOW_EN
                            shadow_d[i] = wr_data;
`else
                            active_d[i] = wr_data;
`endif
                            loaded_d[i] = 1'b1;
                        end
                    end
                end else begin
                    err_oob_d = 1'b1;
                end
            end
        end
    end

    // Next state: follows loaded[] after each accepted write; commit only in FULL.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_EMPTY;
`ifdef WEIGHT_BANK_SHADOW_EN
        end else if (state_q == ST_COMMIT) begin
            state_d = ST_EMPTY;
        end else if (commit && (state_q == ST_FULL)) begin
            state_d = ST_COMMIT;
`endif
        end else if (wr_acc) begin
            if (loaded_d == '0) begin
                state_d = ST_EMPTY;
            end else if (&loaded_d) begin
                state_d = ST_FULL;
            end else begin
                state_d = ST_LOADING;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers, including the weight words themselves.
    always_ff @(posedge clk) begin
        if (!rst) begin
            loaded_q  <= '0;
            err_oob_q <= 1'b0;
            // NOTE: the weight arrays are reset deliberately because the
            // published output must read zero after reset; plain storage
            // arrays normally stay unreset so they map onto RAM.
            for (int i = 0; i < N_WORDS; i++) begin
                active_q[i] <= '0;
`ifdef WEIGHT_BANK_SHADOW_EN
                shadow_q[i] <= '0;
`endif
            end
        end else begin
            loaded_q  <= loaded_d;
            err_oob_q <= err_oob_d;
            active_q  <= active_d;
`ifdef WEIGHT_BANK_SHADOW_EN
            shadow_q  <= shadow_d;
`endif
        end
    end

    popcount #(
        .WIDTH (N_WORDS)
    ) u_popcount (
        .bits  (loaded_q),
        .count (load_cnt)
    );

    for (genvar g = 0; g < N_WORDS; g++) begin : g_flat
        assign w_flat[g*DATA_W +: DATA_W] = active_q[g];
    end

    assign full    = (load_cnt == LCNT_W'(N_WORDS));
    assign err_oob = err_oob_q;

endmodule : weight_bank

// File: tb/tb_weight_bank.sv
// Directed self-checking bench for weight_bank. Expectations follow the
// build option WEIGHT_BANK_SHADOW_EN in the same way as the design.
module tb_weight_bank;

    localparam int DW = 16;
    localparam int NW = 9;
    localparam int AW = 5;
    localparam int BA = 10;
    localparam int CW = $clog2(NW + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_valid;
    logic             wr_ready;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic             commit;
    logic             clear;
    logic [NW*DW-1:0] w_flat;
    logic [CW-1:0]    load_cnt;
    logic             full;
    logic             err_oob;

    int n_tests = 0;
    int n_fail  = 0;

    logic [NW*DW-1:0] exp_w;
    logic [NW*DW-1:0] set1;
    logic [NW*DW-1:0] set2;
    logic [NW*DW-1:0] set3;

    weight_bank #(
        .DATA_W    (DW),
        .N_WORDS   (NW),
        .ADDR_W    (AW),
        .BASE_ADDR (BA)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .commit   (commit),
        .clear    (clear),
        .w_flat   (w_flat),
        .load_cnt (load_cnt),
        .full     (full),
        .err_oob  (err_oob)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input int addr, input logic [DW-1:0] data);
        wr_valid = 1'b1;
        wr_addr  = AW'(addr);
        wr_data  = data;
        tick();
        wr_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        commit = 1'b0; clear = 1'b0;

        for (int i = 0; i < NW; i++) begin
            set1[i*DW +: DW] = DW'(i + 1);
            set2[i*DW +: DW] = DW'(16'h0100 + i);
            set3[i*DW +: DW] = DW'(16'h0200 + i);
        end
        set2[2*DW +: DW] = 16'h00BB;
        set2[0*DW +: DW] = 16'h0777;
`ifdef WEIGHT_BANK_SHADOW_EN
        set2[1*DW +: DW] = 16'h0101;
`else
        set2[1*DW +: DW] = 16'h0999;
`endif

        // Reset state
        tick(); tick();
        check("rst_ready", wr_ready, 0);
        check("rst_wflat", w_flat, 0);
        rst = 1'b1;
        #1;
        check("post_rst_ready", wr_ready, 1);
        check("post_rst_cnt", load_cnt, 0);
        check("post_rst_full", full, 0);
        check("post_rst_err", err_oob, 0);

        // Load addresses 10..18 with 1..9
        exp_w = '0;
        for (int i = 0; i < NW; i++) begin
            write(BA + i, DW'(i + 1));
            if (i == 0) begin
`ifndef WEIGHT_BANK_SHADOW_EN
                exp_w[0 +: DW] = 16'h0001;
`endif
                check("first_write_wflat", w_flat, exp_w);
            end
            if (i == 7) begin
                check("cnt_8", load_cnt, 8);
                check("full_at_8", full, 0);
            end
        end
        check("cnt_9", load_cnt, 9);
        check("full_at_9", full, 1);
`ifdef WEIGHT_BANK_SHADOW_EN
        check("shadow_hidden", w_flat, 0);
        commit = 1'b1; tick(); commit = 1'b0;
        check("commit_ready", wr_ready, 0);
        check("commit_edge1_wflat", w_flat, 0);
        tick();
        check("commit_edge2_wflat", w_flat, set1);
        check("commit_cnt", load_cnt, 0);
        check("commit_full", full, 0);
`else
        check("direct_wflat", w_flat, set1);
        commit = 1'b1; tick(); commit = 1'b0;
        check("commit_ignored_cnt", load_cnt, 9);
        check("commit_ignored_ready", wr_ready, 1);
        tick();
        check("commit_ignored_wflat", w_flat, set1);
        clear = 1'b1; tick(); clear = 1'b0;
        check("clear_cnt", load_cnt, 0);
`endif
        exp_w = set1;

        // Out-of-range writes at both boundaries
        write(BA - 1, 16'hDEAD);
        check("oob_low_err", err_oob, 1);
        check("oob_low_cnt", load_cnt, 0);
        write(BA + NW, 16'hBEEF);
        check("oob_high_err", err_oob, 1);
        check("oob_high_cnt", load_cnt, 0);
        check("oob_wflat", w_flat, exp_w);
        clear = 1'b1; tick(); clear = 1'b0;
        check("clear_err", err_oob, 0);

        // Rewrite of one word, commit while LOADING
        write(12, 16'h00AA);
        write(12, 16'h00BB);
        check("rewrite_cnt", load_cnt, 1);
`ifndef WEIGHT_BANK_SHADOW_EN
        exp_w[2*DW +: DW] = 16'h00BB;
`endif
        commit = 1'b1; tick(); commit = 1'b0;
        check("loading_commit_cnt", load_cnt, 1);
        check("loading_commit_ready", wr_ready, 1);
        check("loading_commit_wflat", w_flat, exp_w);
        for (int i = 0; i < NW; i++) begin
            if (i != 2) write(BA + i, DW'(16'h0100 + i));
        end
        check("refill_full", full, 1);

        // Write with commit in FULL, then hold wr_valid through COMMIT
        wr_valid = 1'b1; wr_addr = AW'(BA); wr_data = 16'h0777; commit = 1'b1;
        tick();
        commit = 1'b0; wr_addr = AW'(BA + 1); wr_data = 16'h0999;
`ifdef WEIGHT_BANK_SHADOW_EN
        check("hold_commit_ready", wr_ready, 0);
        check("hold_commit_wflat", w_flat, set1);
        tick();
        wr_valid = 1'b0;
        check("hold_after_ready", wr_ready, 1);
        check("hold_published", w_flat, set2);
        check("hold_cnt", load_cnt, 0);
`else
        check("hold_direct_ready", wr_ready, 1);
        tick();
        wr_valid = 1'b0;
        check("hold_direct_wflat", w_flat, set2);
        check("hold_direct_cnt", load_cnt, 9);
        clear = 1'b1; tick(); clear = 1'b0;
`endif

        // Clear during COMMIT aborts the publish
        for (int i = 0; i < NW; i++) write(BA + i, DW'(16'h0200 + i));
        commit = 1'b1; tick(); commit = 1'b0;
        clear = 1'b1; tick(); clear = 1'b0;
`ifdef WEIGHT_BANK_SHADOW_EN
        exp_w = set2;
`else
        exp_w = set3;
`endif
        check("abort_wflat", w_flat, exp_w);
        check("abort_cnt", load_cnt, 0);
        check("abort_full", full, 0);
        check("abort_ready", wr_ready, 1);
        tick();
        check("abort_hold_wflat", w_flat, exp_w);

        // Reset in the middle of a load
        for (int i = 0; i < 5; i++) begin
            write(BA + i, DW'(16'h0300 + i));
`ifndef WEIGHT_BANK_SHADOW_EN
            exp_w[i*DW +: DW] = DW'(16'h0300 + i);
`endif
            check("partial_wflat", w_flat, exp_w);
        end
        check("partial_cnt", load_cnt, 5);
        rst = 1'b0;
        #1;
        check("midrst_ready", wr_ready, 0);
        tick();
        check("midrst_wflat", w_flat, 0);
        check("midrst_cnt", load_cnt, 0);
        check("midrst_full", full, 0);
        wr_valid = 1'b1; wr_addr = AW'(BA); wr_data = 16'hFFFF; commit = 1'b1;
        tick();
        check("rst_ignores_write", w_flat, 0);
        check("rst_ignores_cnt", load_cnt, 0);
        wr_valid = 1'b0; commit = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_release_ready", wr_ready, 1);
        tick();
        check("rst_release_cnt", load_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_weight_bank
